// File: rtl/uart_pkg.sv
// Shared types for the UART responder: FSM state encodings and frame geometry.
package uart_pkg;
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_responder_if.sv
// RAM1 low-byte strobe/data bus between the memory controller and the UART responder.
interface uart_responder_if;
  import uart_pkg::*;

  logic                 wrn;
  logic                 rdn;
  logic [DATA_BITS-1:0] bus_wdata;
  logic [DATA_BITS-1:0] bus_rdata;
  logic                 bus_rdata_oe;
  logic                 tbre;
  logic                 tsre;
  logic                 data_ready;
  logic                 overrun;

  modport master (
    output wrn, rdn, bus_wdata,
    input  bus_rdata, bus_rdata_oe, tbre, tsre, data_ready, overrun
  );

  modport slave (
    input  wrn, rdn, bus_wdata,
    output bus_rdata, bus_rdata_oe, tbre, tsre, data_ready, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: rxd synchroniser, start validation at half bit, centre sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data
);
  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [1:0]           sync;
  logic                 rxd_s;
  logic                 rxd_prev;

  assign rxd_s     = sync[1];
  assign byte_data = shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '1;
      rxd_prev <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      sync     <= {sync[0], rxd};
      rxd_prev <= rxd_s;
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    byte_valid = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (rxd_prev && !rxd_s) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rxd_s, shreg[DATA_BITS-1:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        // Leave at the stop-bit centre so a following start edge is never missed.
        if (cnt == CNT_LAST) begin
          cnt_n      = '0;
          byte_valid = rxd_s;
          state_n    = RX_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_responder.sv
// Board-UART stand-in: strobe decode, TX holding/shift path, RX buffer and status flags.
module uart_responder
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  uart_responder_if.slave   bus,
  output logic              txd,
  input  logic              rxd
);
  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic                 wrn_q, rdn_q;
  logic                 write_edge, read_end;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic                 hold_take;
  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [2:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 txd_n;
  logic                 tsre_r, tsre_n;
  logic [DATA_BITS-1:0] rbuf;
  logic                 data_ready_r, overrun_r;
  logic                 byte_valid;
  logic [DATA_BITS-1:0] byte_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  assign write_edge       = wrn_q && !bus.wrn;
  assign read_end         = !rdn_q && bus.rdn;
  // tbre is simply the inverse of the holding-register occupancy.
  assign bus.tbre         = !hold_full;
  assign bus.tsre         = tsre_r;
  assign bus.data_ready   = data_ready_r;
  assign bus.overrun      = overrun_r;
  assign bus.bus_rdata    = rbuf;
  assign bus.bus_rdata_oe = !rdn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrn_q        <= 1'b1;
      rdn_q        <= 1'b1;
      hold         <= '0;
      hold_full    <= 1'b0;
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      txd          <= 1'b1;
      tsre_r       <= 1'b1;
      rbuf         <= '0;
      data_ready_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      wrn_q    <= bus.wrn;
      rdn_q    <= bus.rdn;
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
      tsre_r   <= tsre_n;
      if (write_edge && !hold_full) begin
        hold      <= bus.bus_wdata;
        hold_full <= 1'b1;
      end else if (hold_take) begin
        hold_full <= 1'b0;
      end
      // A byte landing together with a read-end edge wins over the clear.
      if (byte_valid) begin
        rbuf         <= byte_data;
        data_ready_r <= 1'b1;
        overrun_r    <= read_end ? 1'b0 : (overrun_r | data_ready_r);
      end else if (read_end) begin
        data_ready_r <= 1'b0;
        overrun_r    <= 1'b0;
      end
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    tsre_n     = tsre_r;
    hold_take  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        txd_n    = 1'b1;
        if (hold_full) begin
          hold_take  = 1'b1;
          tx_shift_n = hold;
          tsre_n     = 1'b0;
          txd_n      = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          txd_n      = tx_shift[0];
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          tx_bit_n = tx_bit + 1'b1;
          if (tx_bit == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_shift_n = tx_shift >> 1;
            txd_n      = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (hold_full) begin
            hold_take  = 1'b1;
            tx_shift_n = hold;
            txd_n      = 1'b0;
            tx_state_n = TX_START;
          end else begin
            tsre_n     = 1'b1;
            tx_state_n = TX_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_responder.sv
// Randomised bench for uart_responder against a frame-level model of the serial port.
module tb_uart_responder;
  import uart_pkg::*;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
  logic rxd = 1'b1;

  uart_responder_if bus ();

  uart_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd),
    .rxd (rxd)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: receive buffer state and the bytes expected on txd.
  logic [7:0] m_buf;
  logic       m_ready;
  logic       m_overrun;
  logic [7:0] exp_bytes[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks every cycle of the expected serial stream, then some idle cycles.
  task automatic check_tx_stream(input string tag, input int extra);
    int         total;
    logic [9:0] fr;
    logic       e_txd;
    total = FRAME * exp_bytes.size();
    for (int c = 0; c < total + extra; c++) begin
      if (c < total) begin
        fr    = {1'b1, exp_bytes[c / FRAME], 1'b0};
        e_txd = fr[(c % FRAME) / CPB];
      end else begin
        e_txd = 1'b1;
      end
      check({tag, "_txd"}, txd, e_txd);
      check({tag, "_tsre"}, bus.tsre, (c >= total));
      step();
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.bus_wdata = b;
    bus.wrn = 1'b0;
    step();
    check("tbre_clr", bus.tbre, 1'b0);
    bus.wrn = 1'b1;
    step();
    check("tbre_reload", bus.tbre, 1'b1);
  endtask

  task automatic tx_single(input logic [7:0] b);
    write_byte(b);
    exp_bytes = {b};
    check_tx_stream("tx", 4);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input logic collide);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int s = 0; s < FRAME + 4; s++) begin
      rxd = (s < FRAME) ? fr[s / CPB] : 1'b1;
      if (collide && s == FRAME - 2) bus.rdn = 1'b0;
      if (collide && s == FRAME) bus.rdn = 1'b1;
      if (s == FRAME) begin
        check("rx_dr_before", bus.data_ready, m_ready);
        check("rx_ov_before", bus.overrun, m_overrun);
      end
      if (s == FRAME + 1) begin
        if (stop) begin
          m_overrun = collide ? 1'b0 : (m_overrun | m_ready);
          m_ready   = 1'b1;
          m_buf     = b;
        end else if (collide) begin
          m_ready   = 1'b0;
          m_overrun = 1'b0;
        end
        check("rx_dr_after", bus.data_ready, m_ready);
        check("rx_ov_after", bus.overrun, m_overrun);
        check("rx_buf", bus.bus_rdata, m_buf);
      end
      step();
    end
  endtask

  task automatic bus_read();
    bus.rdn = 1'b0;
    step();
    check("rd_oe_on", bus.bus_rdata_oe, 1'b1);
    check("rd_data", bus.bus_rdata, m_buf);
    check("rd_dr", bus.data_ready, m_ready);
    check("rd_ov", bus.overrun, m_overrun);
    step();
    step();
    bus.rdn = 1'b1;
    check("rd_oe_hold", bus.bus_rdata_oe, 1'b1);
    step();
    m_ready   = 1'b0;
    m_overrun = 1'b0;
    check("rd_oe_off", bus.bus_rdata_oe, 1'b0);
    check("rd_dr_clr", bus.data_ready, 1'b0);
    check("rd_ov_clr", bus.overrun, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bus.wrn       = 1'b1;
    bus.rdn       = 1'b1;
    bus.bus_wdata = '0;
    m_buf         = '0;
    m_ready       = 1'b0;
    m_overrun     = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check("rst_txd", txd, 1'b1);
    check("rst_tbre", bus.tbre, 1'b1);
    check("rst_tsre", bus.tsre, 1'b1);
    check("rst_dr", bus.data_ready, 1'b0);
    check("rst_ov", bus.overrun, 1'b0);
    check("rst_oe", bus.bus_rdata_oe, 1'b0);
    check("rst_rdata", bus.bus_rdata, 8'h00);

    tx_single(8'hA5);

    // Back-to-back frames; a write while the holding register is full is dropped.
    write_byte(8'h01);
    exp_bytes = {8'h01, 8'h80};
    fork
      check_tx_stream("b2b", 8);
      begin
        bus.bus_wdata = 8'h80;
        bus.wrn = 1'b0;
        step();
        check("tbre_b2b", bus.tbre, 1'b0);
        bus.wrn = 1'b1;
        repeat (4) step();
        bus.bus_wdata = 8'hFF;
        bus.wrn = 1'b0;
        step();
        bus.wrn = 1'b1;
        check("tbre_drop", bus.tbre, 1'b0);
      end
    join

    repeat (3) begin
      b = 8'($urandom);
      tx_single(b);
    end

    rx_frame(8'h3C, 1'b1, 1'b0);
    bus_read();

    rx_frame(8'h11, 1'b1, 1'b0);
    rx_frame(8'h22, 1'b1, 1'b0);
    bus_read();

    rx_frame(8'h5E, 1'b1, 1'b0);
    // Short low glitch must be taken as a false start.
    rxd = 1'b0;
    repeat (2) step();
    rxd = 1'b1;
    repeat (FRAME + 4) step();
    check("glitch_dr", bus.data_ready, m_ready);
    check("glitch_buf", bus.bus_rdata, m_buf);
    rx_frame(8'hC3, 1'b0, 1'b0);
    bus_read();

    rx_frame(8'h77, 1'b1, 1'b0);
    rx_frame(8'h88, 1'b1, 1'b1);
    bus_read();

    repeat (8) begin
      b = 8'($urandom);
      rx_frame(b, ($urandom_range(0, 4) != 0), 1'b0);
      if ($urandom_range(0, 2) == 0) bus_read();
    end

    rx_frame(8'h6B, 1'b1, 1'b0);
    write_byte(8'h5A);
    repeat (12) step();
    check("mid_bit3", txd, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_buf     = '0;
    m_ready   = 1'b0;
    m_overrun = 1'b0;
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_tbre", bus.tbre, 1'b1);
    check("mid_rst_tsre", bus.tsre, 1'b1);
    check("mid_rst_dr", bus.data_ready, m_ready);
    check("mid_rst_rdata", bus.bus_rdata, m_buf);
    exp_bytes = {};
    check_tx_stream("post_rst", 2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
